// File: rtl/poly_loader_pkg.sv
// Shared Dilithium constants and types for the polynomial loader.
//   DIL_Q        coefficient modulus
//   DIL_N        coefficients per polynomial
//   DIL_N_WORDS  packed BRAM words per polynomial (LANES coefficients each)
//   COEFF_W      width of a signed input coefficient / packed lane
//   RED_W        width of a reduced coefficient
//   load_state_t loader FSM states
package poly_loader_pkg;

  localparam int DIL_Q       = 8380417;
  localparam int DIL_N       = 256;
  localparam int LANES       = 4;
  localparam int DIL_N_WORDS = DIL_N / LANES;
  localparam int COEFF_W     = 24;
  localparam int RED_W       = 23;
  localparam int WORD_W      = LANES * COEFF_W;
  localparam int ADDR_W      = 6;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_FINISH = 2'd2
  } load_state_t;

  // A reduced coefficient occupies the low bits of its lane; the top bit is 0.
  function automatic logic [COEFF_W-1:0] lane_extend(input logic [RED_W-1:0] c);
    return {{(COEFF_W-RED_W){1'b0}}, c};
  endfunction

endpackage

// File: rtl/poly_loader_coeff_reduce.sv
// Maps a signed coefficient into [0, Q-1].
//   data_i   signed two's-complement coefficient
//   coeff_o  reduced coefficient (0 when out of range)
//   err_o    high when data_i lies outside [-Q, Q-1]
module poly_loader_coeff_reduce
  import poly_loader_pkg::*;
#(
  parameter int Q = DIL_Q
) (
  input  logic [COEFF_W-1:0] data_i,
  output logic [RED_W-1:0]   coeff_o,
  output logic               err_o
);

  localparam logic signed [COEFF_W:0] Q_S   = (COEFF_W+1)'(Q);
  localparam logic        [RED_W-1:0] Q_RED = RED_W'(Q);

  logic signed [COEFF_W:0] d_s;

  always_comb begin
    d_s     = {data_i[COEFF_W-1], data_i};
    coeff_o = '0;
    err_o   = 1'b0;
    if (d_s >= 0 && d_s < Q_S) begin
      coeff_o = data_i[RED_W-1:0];
    end else if (d_s < 0 && d_s >= -Q_S) begin
      // The sum lands in [0, Q-1], so modular addition on the low bits is exact.
      coeff_o = data_i[RED_W-1:0] + Q_RED;
    end else begin
      err_o = 1'b1;
    end
  end

endmodule

// File: rtl/poly_loader.sv
// Streams one polynomial of signed coefficients into BRAM port B, four
// reduced coefficients per 96-bit word.
//   clk      clock
//   rst      asynchronous active-low reset
//   start    one-cycle pulse in IDLE begins a load
//   valid_i  data_i carries a coefficient
//   data_i   signed 24-bit coefficient
//   ready_o  loader accepts a coefficient this cycle (LOAD state)
//   addrb    BRAM write address (word index)
//   web      BRAM write enable
//   dib      BRAM write data, lane j at [24j+23:24j]
//   done     one-cycle pulse after the last word is written
//   error    sticky: an out-of-range coefficient was seen in this load
module poly_loader
  import poly_loader_pkg::*;
#(
  parameter int Q       = DIL_Q,
  parameter int N_WORDS = DIL_N_WORDS
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               valid_i,
  input  logic [COEFF_W-1:0] data_i,
  output logic               ready_o,
  output logic [ADDR_W-1:0]  addrb,
  output logic               web,
  output logic [WORD_W-1:0]  dib,
  output logic               done,
  output logic               error
);

  localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(N_WORDS - 1);

  load_state_t        state_q, state_d;
  logic [1:0]         lane_q, lane_d;
  logic [ADDR_W-1:0]  word_q, word_d;
  logic [WORD_W-1:0]  pack_q, pack_d;
  logic               web_q, web_d;
  logic [ADDR_W-1:0]  addrb_q, addrb_d;
  logic [WORD_W-1:0]  dib_q, dib_d;
  logic               done_q, done_d;
  logic               error_q, error_d;

  logic [RED_W-1:0]   red_coeff;
  logic               red_err;
  logic [COEFF_W-1:0] lane_val;
  logic               accept;

  poly_loader_coeff_reduce #(
    .Q(Q)
  ) u_coeff_reduce (
    .data_i (data_i),
    .coeff_o(red_coeff),
    .err_o  (red_err)
  );

  assign ready_o = (state_q == ST_LOAD);
  assign accept  = valid_i && ready_o;

  always_comb begin
    state_d  = state_q;
    lane_d   = lane_q;
    word_d   = word_q;
    pack_d   = pack_q;
    web_d    = 1'b0;
    addrb_d  = addrb_q;
    dib_d    = dib_q;
    done_d   = 1'b0;
    error_d  = error_q;
    lane_val = lane_extend(red_coeff);

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_LOAD;
          lane_d  = '0;
          word_d  = '0;
          error_d = 1'b0;
        end
      end

      ST_LOAD: begin
        if (accept) begin
          lane_d  = lane_q + 2'd1;
          error_d = error_q | red_err;
          for (int unsigned j = 0; j < LANES; j++) begin
            if (lane_q == 2'(j)) begin
              pack_d[j*COEFF_W +: COEFF_W] = lane_val;
            end
          end
          // The fourth lane completes the word; pack_d already includes it.
          if (lane_q == 2'd3) begin
            web_d   = 1'b1;
            addrb_d = word_q;
            dib_d   = pack_d;
          end
        end
        // The word counter advances in the cycle the write is visible, so the
        // final wrap lines up with entry to FINISH.
        if (web_q) begin
          if (word_q == LAST_WORD) begin
            word_d  = '0;
            state_d = ST_FINISH;
            done_d  = 1'b1;
          end else begin
            word_d = word_q + 1'b1;
          end
        end
      end

      ST_FINISH: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      lane_q  <= '0;
      word_q  <= '0;
      pack_q  <= '0;
      web_q   <= 1'b0;
      addrb_q <= '0;
      dib_q   <= '0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      lane_q  <= lane_d;
      word_q  <= word_d;
      pack_q  <= pack_d;
      web_q   <= web_d;
      addrb_q <= addrb_d;
      dib_q   <= dib_d;
      done_q  <= done_d;
      error_q <= error_d;
    end
  end

  assign web   = web_q;
  assign addrb = addrb_q;
  assign dib   = dib_q;
  assign done  = done_q;
  assign error = error_q;

endmodule

// File: doc/poly_loader.md
POLY_LOADER -- requirements
Module: poly_loader

Interface
REQ-001 Parameter Q, default 8380417, coefficient modulus.
REQ-002 Parameter N_WORDS, default 64, packed words per polynomial (4 coefficients per word).
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 start  input  1  one-cycle pulse; begins loading one polynomial.
REQ-006 valid_i  input  1  coefficient on data_i is valid.
REQ-007 data_i  input  24  signed two's-complement coefficient.
REQ-008 ready_o  output  1  loader accepts a coefficient this cycle.
REQ-009 addrb  output  6  BRAM write address.
REQ-010 web  output  1  BRAM write enable.
REQ-011 dib  output  96  BRAM write data.
REQ-012 done  output  1  one-cycle pulse after the last word is written.
REQ-013 error  output  1  sticky flag: an out-of-range coefficient was seen in the current load.

Function
REQ-014 States IDLE, LOAD, FINISH; IDLE -> LOAD on start; LOAD -> FINISH the cycle after the 4*N_WORDS-th accept; FINISH -> IDLE unconditionally after one cycle.
REQ-015 ready_o is combinational and equals (state == LOAD); a transfer occurs when valid_i and ready_o are both high.
REQ-016 start is ignored in LOAD and FINISH; a start in IDLE clears the lane counter, word counter and error.
REQ-017 Reduction: data_i in [0, Q-1] passes unchanged; data_i in [-Q, -1] maps to data_i + Q; any other value writes 0 and sets error.
REQ-018 Reduced values are 23 bits, zero-extended to a 24-bit lane.
REQ-019 Lane counter (2 bits) selects the lane for each accept; coefficient 4a+j goes to lane j of word a, and lane j occupies dib[24j+23:24j].
REQ-020 A lane counter wrap (4th accept of a word) registers the packed word; web is high exactly one cycle later, with addrb equal to the word index and dib equal to the packed word.
REQ-021 The word counter increments on each write and wraps from N_WORDS-1 to 0; the wrap coincides with entry to FINISH.
REQ-022 done pulses high for exactly the FINISH cycle, which is the cycle after the final web pulse.
REQ-023 web, addrb and dib are registered outputs; when web is low, addrb and dib hold their last values.
REQ-024 Gaps (valid_i low) in LOAD are allowed; counters hold and no write occurs.
REQ-025 error stays asserted through FINISH and IDLE until the next accepted start.

Reset
REQ-026 While rst is low: state = IDLE, counters = 0, web = 0, addrb = 0, dib = 0, done = 0, error = 0, ready_o = 0.
REQ-027 If rst is asserted mid-load, the load is discarded and no done is produced; a fresh start is required after rst deasserts.

Structure
REQ-028 Q, N_WORDS and the state encoding SHALL live in the shared Dilithium package, alongside the other arithmetic constants.
REQ-029 One sub-module, coeff_reduce (combinational range check plus conditional add of Q, with an error output), SHALL be instantiated once.
REQ-030 Outputs SHALL connect directly to BRAM 1 port B (addrb1/web1/dib1) of the operation datapath, so one polynomial is loaded before the NTT start.

Verification
REQ-031 start, then coefficients 0..255 with valid_i held high -> web high on 64 cycles, starting 5 cycles after start (the first accept is the cycle after start); word a = {4a+3, 4a+2, 4a+1, 4a}; done one cycle after the last web; error = 0.
REQ-032 Inputs -1, -Q, Q-1, Q in lanes 0..3 -> lanes Q-1, 0, Q-1, 0 in word 0; error = 1 and held until the next start.
REQ-033 valid_i toggled randomly at 50% -> the 64 written words are identical to REQ-031; no extra web pulses.
REQ-034 start pulsed again during LOAD after 100 accepts -> ignored; done after exactly 256 accepts.
REQ-035 rst low after 130 accepts, then released -> all outputs at reset values, no done; a following start and 256 accepts complete normally.
REQ-036 valid_i high in IDLE and FINISH -> ready_o = 0 and no write occurs.
